// File: rtl/bcd_tens_stage_pkg.sv
// Shared BCD digit types and helpers for the counter chain.
// Used by the tens stage and its rollover detector.
package contador_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_tens_stage_if.sv
// Digit bus between the units counter and the tens stage.
// master = upstream/driver side, slave = tens stage.
interface bcd_tens_stage_if;
    import contador_pkg::*;

    logic       en;
    logic       units_clr;
    bcd_digit_t units_q;
    bcd_digit_t tens_q;
    logic       wrap_pulse;
    logic       carry_out;
    logic       bad_digit;
    logic       seq_err;

    modport master (
        output en, units_clr, units_q,
        input  tens_q, wrap_pulse, carry_out, bad_digit, seq_err
    );

    modport slave (
        input  en, units_clr, units_q,
        output tens_q, wrap_pulse, carry_out, bad_digit, seq_err
    );

endinterface

// File: rtl/bcd_tens_stage_wrap_detect.sv
// Tracks the previous units sample and flags the 9->0 rollover.
// Optional sequence checker enabled by BCD_TENS_SEQ_CHECK_EN.
module bcd_wrap_detect
    import contador_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          units_clr,
    input  logic [DW-1:0] units_q,
    output logic          wrap,
    output logic          seq_hit
);

    logic [DW-1:0] prev_q;
    logic          prev_vld;
    logic          sample;

    assign sample = en && !units_clr;

    assign wrap = sample && prev_vld
               && (prev_q == BCD_MAX)
               && (units_q == BCD_MIN);

    // Previous-sample register; a clear restarts detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q   <= '0;
            prev_vld <= 1'b0;
        end else if (en) begin
            if (units_clr) begin
                prev_q   <= '0;
                prev_vld <= 1'b0;
            end else begin
                prev_q   <= units_q;
                prev_vld <= 1'b1;
            end
        end
    end

`ifdef BCD_TENS_SEQ_CHECK_EN
    logic step_ok;

    // Legal successors: stall, +1 below 9, or 0 after 9.
    always_comb begin
        step_ok = (units_q == prev_q);
        if (prev_q == BCD_MAX) begin
            step_ok = step_ok | (units_q == BCD_MIN);
        end else if (prev_q < BCD_MAX) begin
            step_ok = step_ok | (units_q == prev_q + 1'b1);
        end
    end

    assign seq_hit = sample && prev_vld && !step_ok;
`else
    assign seq_hit = 1'b0;
`endif

endmodule

// File: rtl/bcd_tens_stage.sv
// Tens digit stage: counts units rollovers, emits wrap/carry pulses.
// Optional feature macro: BCD_TENS_SEQ_CHECK_EN (sticky seq_err).
module bcd_tens_stage
    import contador_pkg::*;
#(
    parameter int TENS_MAX = 9,
    parameter int DW       = 4
) (
    input  logic        clk,
    input  logic        reset,
    bcd_tens_stage_if.slave bus
);

    localparam logic [DW-1:0] TMAX = DW'(TENS_MAX);

    logic [DW-1:0] tens_r;
    logic          wrap_r;
    logic          carry_r;
    logic          bad_r;
    logic          seq_r;
    logic          wrap;
    logic          seq_hit;

    bcd_wrap_detect #(
        .DW(DW)
    ) u_det (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .units_clr(bus.units_clr),
        .units_q  (bus.units_q),
        .wrap     (wrap),
        .seq_hit  (seq_hit)
    );

    // Tens counter, one-cycle pulses and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tens_r  <= '0;
            wrap_r  <= 1'b0;
            carry_r <= 1'b0;
            bad_r   <= 1'b0;
            seq_r   <= 1'b0;
        end else if (!bus.en) begin
            wrap_r  <= 1'b0;
            carry_r <= 1'b0;
        end else begin
            wrap_r  <= wrap;
            carry_r <= 1'b0;
            if (wrap) begin
                if (tens_r == TMAX) begin
                    tens_r  <= '0;
                    carry_r <= 1'b1;
                end else begin
                    tens_r <= tens_r + 1'b1;
                end
            end
            if (!is_bcd(bus.units_q)) begin
                bad_r <= 1'b1;
            end
            if (seq_hit) begin
                seq_r <= 1'b1;
            end
        end
    end

    assign bus.tens_q     = tens_r;
    assign bus.wrap_pulse = wrap_r;
    assign bus.carry_out  = carry_r;
    assign bus.bad_digit  = bad_r;
    assign bus.seq_err    = seq_r;

endmodule

// File: tb/tb_bcd_tens_stage.sv
// Directed bench for bcd_tens_stage with a reference model scoreboard.
// Honours BCD_TENS_SEQ_CHECK_EN for the expected seq_err.
module tb_bcd_tens_stage;
    import contador_pkg::*;

    typedef struct {
        logic [3:0] tens;
        logic       wp;
        logic       co;
        logic       bad;
        logic       se;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   wraps = 0;
    int   carries = 0;

    exp_t sb[$];

    logic [3:0] m_tens;
    logic [3:0] m_prev;
    logic       m_vld;
    logic       m_bad;
    logic       m_se;

    bcd_tens_stage_if bus ();

    bcd_tens_stage #(
        .TENS_MAX(9),
        .DW      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rst, input logic e, input logic c,
                        input logic [3:0] q);
        exp_t x;
        logic w;
        logic ok;
        x.wp = 1'b0;
        x.co = 1'b0;
        if (!rst) begin
            m_tens = 0; m_prev = 0; m_vld = 0; m_bad = 0; m_se = 0;
        end else if (e) begin
            if (q > 4'd9) m_bad = 1'b1;
            if (c) begin
                m_prev = 0;
                m_vld = 0;
            end else begin
                w = m_vld && m_prev == 4'd9 && q == 4'd0;
                ok = (q == m_prev)
                  || (m_prev < 4'd9 && q == m_prev + 4'd1)
                  || (m_prev == 4'd9 && q == 4'd0);
`ifdef BCD_TENS_SEQ_CHECK_EN
                if (m_vld && !ok) m_se = 1'b1;
`endif
                m_prev = q;
                m_vld = 1'b1;
                if (w) begin
                    x.wp = 1'b1;
                    if (m_tens == 4'd9) begin
                        m_tens = 0;
                        x.co = 1'b1;
                    end else begin
                        m_tens = m_tens + 4'd1;
                    end
                end
            end
        end
        x.tens = m_tens;
        x.bad = m_bad;
        x.se = m_se;
        sb.push_back(x);
        reset = rst;
        bus.en = e;
        bus.units_clr = c;
        bus.units_q = q;
        @(posedge clk);
        #1;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("tens_q", bus.tens_q, x.tens);
            chk("wrap_pulse", {3'b0, bus.wrap_pulse}, {3'b0, x.wp});
            chk("carry_out", {3'b0, bus.carry_out}, {3'b0, x.co});
            chk("bad_digit", {3'b0, bus.bad_digit}, {3'b0, x.bad});
            chk("seq_err", {3'b0, bus.seq_err}, {3'b0, x.se});
        end
        if (bus.wrap_pulse) wraps++;
        if (bus.carry_out) carries++;
    endtask

    task automatic count_up(input int lo, input int hi);
        for (int u = lo; u <= hi; u++) step(1, 1, 0, 4'(u));
    endtask

    int t0;

    initial begin
        reset = 1'b0;
        bus.en = 1'b1;
        bus.units_clr = 1'b0;
        bus.units_q = 4'd9;
        m_tens = 0; m_prev = 0; m_vld = 0; m_bad = 0; m_se = 0;

        // reset hold with units=9, then first sample 0 gives no wrap
        repeat (3) step(0, 1, 0, 4'd9);
        step(1, 1, 0, 4'd0);

        // twelve decades: 10th wrap carries
        for (int d = 0; d < 12; d++) begin
            count_up(1, 9);
            step(1, 1, 0, 4'd0);
        end
        chk("wrap_count", 4'(wraps), 4'd12);
        chk("carry_count", 4'(carries), 4'd1);
        chk("tens_after12", bus.tens_q, 4'd2);

        // enable stall across 9->0
        count_up(1, 9);
        t0 = int'(bus.tens_q);
        step(1, 0, 0, 4'd9);
        step(1, 0, 0, 4'd9);
        step(1, 0, 0, 4'd0);
        step(1, 0, 0, 4'd0);
        step(1, 0, 0, 4'd0);
        chk("stall_hold", bus.tens_q, 4'(t0));
        step(1, 1, 0, 4'd0);
        chk("stall_inc", bus.tens_q, 4'(t0 + 1));

        // clear suppression, then unguarded clear from 9 counts
        count_up(1, 9);
        t0 = int'(bus.tens_q);
        step(1, 1, 1, 4'd0);
        step(1, 1, 0, 4'd0);
        chk("clr_hold", bus.tens_q, 4'(t0));
        count_up(1, 9);
        step(1, 1, 0, 4'd0);
        chk("noclr_inc", bus.tens_q, 4'(t0 + 1));

        // sequence: stall 4->4 legal, then 3->5 jump
        step(1, 1, 1, 4'd0);
        count_up(1, 4);
        step(1, 1, 0, 4'd4);
        step(1, 1, 1, 4'd0);
        step(1, 1, 0, 4'd3);
        step(1, 1, 0, 4'd5);

        // illegal digit while cleared and while counting
        step(0, 1, 0, 4'd0);
        step(1, 1, 0, 4'd0);
        t0 = int'(bus.tens_q);
        step(1, 1, 0, 4'd12);
        step(1, 1, 0, 4'd0);
        step(1, 1, 0, 4'd1);
        chk("bad_tens", bus.tens_q, 4'(t0));
        step(0, 1, 0, 4'd0);
        step(1, 1, 1, 4'd14);
        step(0, 1, 0, 4'd0);
        step(1, 1, 0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_tens_stage.md
Name: bcd_tens_stage

Overview:
- Downstream stage of the mod-10 units counter (`Contador`).
- Samples the units digit `q` every clock and detects the 9->0 rollover.
- Advances a tens digit on each rollover and emits a one-cycle wrap pulse.
- Emits a carry when the tens digit itself wraps, so further stages can cascade; also flags illegal digits.

Parameters:
- TENS_MAX, 9: terminal value of the tens digit; tens counts 0..TENS_MAX; legal range 1..15.
- DW, 4: digit width in bits; fixed at 4 for BCD, kept as a parameter for package consistency.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  in  1  stage enable; 0 = hold all state, including the previous-sample register.
- units_clr  in  1  high in cycles where the upstream counter is being cleared; suppresses rollover detection.
- units_q  in  DW  units digit from the upstream counter.
- tens_q  out  DW  tens digit, registered.
- wrap_pulse  out  1  one-cycle pulse per detected 9->0 rollover, registered.
- carry_out  out  1  one-cycle pulse when tens_q wraps TENS_MAX->0, registered.
- bad_digit  out  1  sticky flag: a units_q value >9 was sampled.
- seq_err  out  1  sticky sequence-error flag; present only with the optional feature (see below).

Behaviour:
- Reset (reset==0 at an edge):
  - tens_q=0, wrap_pulse=0, carry_out=0, bad_digit=0, seq_err=0.
  - prev_q=0, prev_vld=0.
  - Reset dominates en and units_clr.
- Internal state:
  - prev_q (DW bits): last sampled units_q.
  - prev_vld: 0 until the first enabled, non-clear sample after reset or clear.
- Edge with en=0: all registers hold; wrap_pulse and carry_out are forced to 0.
- Edge with en=1, units_clr=1:
  - prev_vld <= 0, prev_q <= 0.
  - No wrap; tens_q holds; pulses are 0.
- Edge with en=1, units_clr=0:
  - wrap = prev_vld && prev_q==9 && units_q==0.
  - prev_q <= units_q; prev_vld <= 1.
  - If wrap: wrap_pulse <= 1.
    - If tens_q==TENS_MAX: tens_q <= 0, carry_out <= 1.
    - Otherwise: tens_q <= tens_q+1, carry_out <= 0.
  - Otherwise: pulses <= 0 and tens_q holds.
- Latency:
  - tens_q and wrap_pulse change at the same edge that samples units_q==0 after a sampled 9.
  - Both are visible one cycle after the upstream digit shows 0.
- Pulse width: wrap_pulse and carry_out never stay high two consecutive cycles, because the upstream counter cannot produce 9->0 on back-to-back samples.
- bad_digit:
  - Set at any enabled edge sampling units_q>9, including while units_clr=1.
  - Cleared only by reset.
  - An illegal digit updates prev_q as normal; it never matches 9, so no wrap follows from it.
- Boundaries:
  - First sample after reset equal to 0: no wrap, since prev_vld=0.
  - Upstream cleared from 9 with units_clr asserted: no wrap.
  - Upstream cleared from 9 without units_clr: indistinguishable from a rollover, so it counts. This is intended; the integrator must drive units_clr.
  - TENS_MAX<9: tens_q wraps early.
  - tens_q never exceeds TENS_MAX.

Optional Feature:
- Macro: BCD_TENS_SEQ_CHECK_EN.
- Defined:
  - At enabled, non-clear edges with prev_vld=1, units_q must equal prev_q (stall), or prev_q+1 (prev_q<9), or 0 (prev_q==9).
  - Any other value sets seq_err (sticky, cleared by reset).
  - Counting behaviour is unchanged.
- Undefined: seq_err is tied to 0 and the checker logic is absent.

Decomposition:
- Package `contador_pkg`:
  - typedef `bcd_digit_t` (logic [3:0]).
  - localparams BCD_MAX=9 and BCD_MIN=0.
  - Function `is_bcd()`, returning units_q<=BCD_MAX.
- Sub-module `bcd_wrap_detect`:
  - Owns prev_q, prev_vld and the optional sequence checker.
  - Outputs a combinational `wrap` and the checker error to the parent.
  - The parent owns tens_q, the pulses and the sticky flags.

Test Plan:
- Reset hold: reset=0 for 3 edges with units_q=9 -> all outputs 0; first enabled sample of 0 after release gives no wrap_pulse.
- Normal count: drive 0..9,0 repeatedly for 12 decades with TENS_MAX=9 ->
  - wrap_pulse once per decade, in the cycle after the 0 sample;
  - tens_q reaches 9 after 9 decades;
  - on the 10th wrap, tens_q returns to 0 with carry_out=1 for exactly 1 cycle.
- Enable stall: en=0 for 5 cycles spanning the 9->0 change ->
  - no pulse while en=0; tens_q unchanged;
  - after en=1, the wrap is detected only if the first sample is 0 with prev_q still 9, and tens_q increments by exactly 1.
- Clear suppression: units_q=9, then units_clr=1 with units_q=0 -> no wrap and tens_q unchanged. Repeat without units_clr -> tens_q+1.
- Illegal digit: units_q=12 for one cycle -> bad_digit=1 from the next cycle and stays 1 until reset=0; tens_q unaffected.
- Sequence check (macro defined): units_q goes 3->5 -> seq_err=1 next cycle. Stall 4->4 and normal 9->0 leave it 0. With the macro undefined, seq_err stays 0.
